// File: rtl/switch_alloc_ctrl_pkg.sv
// Shared NoC types for the switch-allocation front end: port ids, lock states, VC identifiers.
// The optional lock timeout (SA_LOCK_TIMEOUT_EN) needs no package support.
package switch_alloc_ctrl_pkg;

    localparam int unsigned PORT_NUM   = 5;
    localparam int unsigned PORT_W     = 3;
    localparam int unsigned VC_NUM_DEF = 2;
    localparam int unsigned VC_W       = (VC_NUM_DEF > 1) ? $clog2(VC_NUM_DEF) : 1;
    localparam int unsigned VCID_W     = PORT_W + VC_W;

    typedef enum logic [PORT_W-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        EAST  = 3'd3,
        WEST  = 3'd4
    } port_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    typedef struct packed {
        port_t           port;
        logic [VC_W-1:0] vc;
    } vc_id_t;

    // Packs an (input port, vc) loop index pair into a vc_id_t.
    function automatic vc_id_t make_vc_id(input int unsigned ip, input int unsigned iv);
        vc_id_t id;
        id.port = port_t'(PORT_W'(ip));
        id.vc   = VC_W'(iv);
        return id;
    endfunction

endpackage

// File: rtl/switch_alloc_ctrl_out_port_lock.sv
// Per-output state: packet lock FSM with owner, downstream credit counter and,
// with SA_LOCK_TIMEOUT_EN defined, an idle-owner timeout that force-releases the lock.
module out_port_lock
    import switch_alloc_ctrl_pkg::*;
#(
    parameter int unsigned BUF_DEPTH    = 4,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              RSTn,
    input  logic              i_grant_valid,
    input  logic [VCID_W-1:0] i_grant_id,
    input  logic              i_grant_head,
    input  logic              i_grant_tail,
    input  logic              i_credit,
    input  logic              i_owner_req,
    output logic              o_locked_c,
    output logic [VCID_W-1:0] o_owner,
    output logic              o_credit_ok_c,
    output logic              o_credit_err_c,
    output logic              o_timeout_c
);

    localparam int unsigned       CRED_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);

    lock_state_t       r_state;
    lock_state_t       w_state_next;
    vc_id_t            r_owner;
    vc_id_t            w_owner_next;
    vc_id_t            w_grant_id;
    logic [CRED_W-1:0] r_credit;
    logic [CRED_W-1:0] w_credit_next;
    logic              w_owner_hit;
    logic              w_timeout;

    assign w_grant_id  = vc_id_t'(i_grant_id);
    assign w_owner_hit = i_grant_valid && (w_grant_id == r_owner);

`ifdef SA_LOCK_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(LOCK_TIMEOUT + 1);

    logic [TO_W-1:0] r_idle;
    logic [TO_W-1:0] w_idle_next;

    // Consecutive locked cycles with the owner not requesting; any owner request restarts the count.
    always_comb begin
        w_idle_next = '0;
        w_timeout   = 1'b0;
        if (r_state == LOCKED && !i_owner_req) begin
            if (r_idle == TO_W'(LOCK_TIMEOUT - 1)) begin
                w_timeout = 1'b1;
            end else begin
                w_idle_next = r_idle + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_idle <= '0;
        end else begin
            r_idle <= w_idle_next;
        end
    end
`else
    logic w_unused_ok;

    assign w_timeout   = 1'b0;
    assign w_unused_ok = i_owner_req | (LOCK_TIMEOUT == 0);
`endif

    // Lock next state: heads of multi-flit packets lock, the owner's tail (or a timeout) releases.
    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        case (r_state)
            UNLOCKED: begin
                if (i_grant_valid && i_grant_head && !i_grant_tail) begin
                    w_state_next = LOCKED;
                    w_owner_next = w_grant_id;
                end
            end
            LOCKED: begin
                if (w_timeout || (w_owner_hit && i_grant_tail)) begin
                    w_state_next = UNLOCKED;
                end
            end
            default: w_state_next = UNLOCKED;
        endcase
    end

    // A grant and a returned credit in the same cycle cancel out.
    always_comb begin
        w_credit_next  = r_credit;
        o_credit_err_c = i_credit && (r_credit == CRED_MAX);
        if (i_grant_valid && !i_credit) begin
            if (r_credit != '0) begin
                w_credit_next = r_credit - CRED_W'(1);
            end
        end else if (i_credit && !i_grant_valid && (r_credit != CRED_MAX)) begin
            w_credit_next = r_credit + CRED_W'(1);
        end
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_state  <= UNLOCKED;
            r_owner  <= '0;
            r_credit <= CRED_MAX;
        end else begin
            r_state  <= w_state_next;
            r_owner  <= w_owner_next;
            r_credit <= w_credit_next;
        end
    end

    assign o_locked_c    = (r_state == LOCKED);
    assign o_owner       = r_owner;
    assign o_credit_ok_c = (r_credit != '0);
    assign o_timeout_c   = w_timeout;

endmodule

// File: rtl/switch_alloc_ctrl.sv
// Credit-aware, packet-locking front end for the wavefront allocator: masks VC requests,
// registers grants as switch-traversal grants and crossbar selects. Optional macro: SA_LOCK_TIMEOUT_EN.
module switch_alloc_ctrl
    import switch_alloc_ctrl_pkg::*;
#(
    parameter int unsigned VC_NUM       = VC_NUM_DEF,
    parameter int unsigned BUF_DEPTH    = 4,
    parameter int unsigned LOCK_TIMEOUT = 64
) (
    input  logic                                   clk,
    input  logic                                   RSTn,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]             vc_request_in,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_W-1:0] vc_target_port,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]             vc_is_head,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]             vc_is_tail,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]             alloc_request,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]             alloc_grant,
    input  logic [PORT_NUM-1:0]                         credit_in,
    output logic [PORT_NUM-1:0][VC_NUM-1:0]             sw_grant,
    output logic [PORT_NUM-1:0]                         xbar_valid,
    output logic [PORT_NUM-1:0][PORT_W-1:0]             xbar_sel,
    output logic                                        credit_err,
    output logic                                        timeout_err
);

    logic [PORT_NUM-1:0]              w_locked;
    logic [PORT_NUM-1:0]              w_credit_ok;
    logic [PORT_NUM-1:0]              w_cred_err;
    logic [PORT_NUM-1:0]              w_timeout;
    logic [PORT_NUM-1:0]              w_owner_req;
    logic [PORT_NUM-1:0][VCID_W-1:0]  w_owner;
    logic [PORT_NUM-1:0]              w_gnt_valid;
    logic [PORT_NUM-1:0]              w_gnt_head;
    logic [PORT_NUM-1:0]              w_gnt_tail;
    logic [PORT_NUM-1:0][VCID_W-1:0]  w_gnt_id;

    logic [PORT_NUM-1:0][VC_NUM-1:0]  r_sw_grant;
    logic [PORT_NUM-1:0]              r_xbar_valid;
    logic [PORT_NUM-1:0][PORT_W-1:0]  r_xbar_sel;
    logic                             r_credit_err;
    logic                             r_timeout_err;

    // Request mask from registered state only: credit available, and either the output's
    // lock owner or, for an unlocked output, a packet head.
    always_comb begin
        logic [PORT_W-1:0] w_op;
        alloc_request = '0;
        w_op          = '0;
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            for (int iv = 0; iv < VC_NUM; iv++) begin
                w_op = vc_target_port[ip][iv];
                if (vc_request_in[ip][iv] && (int'(w_op) < PORT_NUM)) begin
                    if (w_credit_ok[w_op]) begin
                        if (w_locked[w_op]) begin
                            alloc_request[ip][iv] = (w_owner[w_op] == make_vc_id(ip, iv));
                        end else begin
                            alloc_request[ip][iv] = vc_is_head[ip][iv];
                        end
                    end
                end
            end
        end
    end

    // Fold the per-VC grant matrix into one grant record per output port.
    always_comb begin
        logic [PORT_W-1:0] w_op;
        w_gnt_valid = '0;
        w_gnt_head  = '0;
        w_gnt_tail  = '0;
        w_gnt_id    = '0;
        w_op        = '0;
        for (int ip = 0; ip < PORT_NUM; ip++) begin
            for (int iv = 0; iv < VC_NUM; iv++) begin
                w_op = vc_target_port[ip][iv];
                if (alloc_grant[ip][iv] && (int'(w_op) < PORT_NUM)) begin
                    w_gnt_valid[w_op] = 1'b1;
                    w_gnt_head[w_op]  = vc_is_head[ip][iv];
                    w_gnt_tail[w_op]  = vc_is_tail[ip][iv];
                    w_gnt_id[w_op]    = make_vc_id(ip, iv);
                end
            end
        end
    end

    always_comb begin
        vc_id_t w_own;
        w_owner_req = '0;
        w_own       = '0;
        for (int op = 0; op < PORT_NUM; op++) begin
            w_own = vc_id_t'(w_owner[op]);
            if ((int'(w_own.port) < PORT_NUM) && (int'(w_own.vc) < VC_NUM)) begin
                w_owner_req[op] = alloc_request[w_own.port][w_own.vc];
            end
        end
    end

    for (genvar g = 0; g < PORT_NUM; g++) begin : g_out
        out_port_lock #(
            .BUF_DEPTH    (BUF_DEPTH),
            .LOCK_TIMEOUT (LOCK_TIMEOUT)
        ) u_lock (
            .clk            (clk),
            .RSTn           (RSTn),
            .i_grant_valid  (w_gnt_valid[g]),
            .i_grant_id     (w_gnt_id[g]),
            .i_grant_head   (w_gnt_head[g]),
            .i_grant_tail   (w_gnt_tail[g]),
            .i_credit       (credit_in[g]),
            .i_owner_req    (w_owner_req[g]),
            .o_locked_c     (w_locked[g]),
            .o_owner        (w_owner[g]),
            .o_credit_ok_c  (w_credit_ok[g]),
            .o_credit_err_c (w_cred_err[g]),
            .o_timeout_c    (w_timeout[g])
        );
    end

    // Output stage; xbar_sel keeps its last source while its output is idle.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_sw_grant    <= '0;
            r_xbar_valid  <= '0;
            r_xbar_sel    <= '0;
            r_credit_err  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_sw_grant    <= alloc_grant;
            r_xbar_valid  <= w_gnt_valid;
            for (int op = 0; op < PORT_NUM; op++) begin
                if (w_gnt_valid[op]) begin
                    r_xbar_sel[op] <= w_gnt_id[op][VCID_W-1 -: PORT_W];
                end
            end
            r_credit_err  <= r_credit_err | (|w_cred_err);
            r_timeout_err <= r_timeout_err | (|w_timeout);
        end
    end

    assign sw_grant   = r_sw_grant;
    assign xbar_valid = r_xbar_valid;
    assign xbar_sel   = r_xbar_sel;
    assign credit_err = r_credit_err;

`ifdef SA_LOCK_TIMEOUT_EN
    assign timeout_err = r_timeout_err;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_switch_alloc_ctrl.sv
// Self-checking bench for switch_alloc_ctrl: directed scenarios plus randomized traffic against a
// behavioural model; the bench plays the allocator. Timeout scenario runs only with SA_LOCK_TIMEOUT_EN.
module tb_switch_alloc_ctrl;

    localparam int PN = 5;
    localparam int VN = 2;
    localparam int BD = 4;
    localparam int LT = 8;

    logic                      clk = 1'b0;
    logic                      RSTn;
    logic [PN-1:0][VN-1:0]       req, head, tail, areq, agnt, swg;
    logic [PN-1:0][VN-1:0][2:0]  tgt;
    logic [PN-1:0]               cin, xv;
    logic [PN-1:0][2:0]          xs;
    logic                        cerr, terr;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    int                    m_cred [PN];
    bit                    m_lock [PN];
    int                    m_own_ip [PN];
    int                    m_own_vc [PN];
    int                    m_idle [PN];
    bit                    m_cerr, m_terr;
    logic [PN-1:0][VN-1:0] m_req, e_swg, s_areq;
    logic [PN-1:0]         e_xv;
    logic [PN-1:0][2:0]    e_xs;

    switch_alloc_ctrl #(.VC_NUM(VN), .BUF_DEPTH(BD), .LOCK_TIMEOUT(LT)) dut (
        .clk            (clk),
        .RSTn           (RSTn),
        .vc_request_in  (req),
        .vc_target_port (tgt),
        .vc_is_head     (head),
        .vc_is_tail     (tail),
        .alloc_request  (areq),
        .alloc_grant    (agnt),
        .credit_in      (cin),
        .sw_grant       (swg),
        .xbar_valid     (xv),
        .xbar_sel       (xs),
        .credit_err     (cerr),
        .timeout_err    (terr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        req = '0; head = '0; tail = '0; tgt = '0; cin = '0; agnt = '0;
    endtask

    task automatic model_reset();
        for (int op = 0; op < PN; op++) begin
            m_cred[op] = BD; m_lock[op] = 0; m_own_ip[op] = 0; m_own_vc[op] = 0; m_idle[op] = 0;
        end
        m_cerr = 0; m_terr = 0; e_swg = '0; e_xv = '0; e_xs = '0;
    endtask

    function automatic void compute_m_req();
        int op;
        m_req = '0;
        for (int ip = 0; ip < PN; ip++)
            for (int iv = 0; iv < VN; iv++) begin
                op = int'(tgt[ip][iv]);
                if (req[ip][iv] && op < PN && m_cred[op] > 0)
                    m_req[ip][iv] = m_lock[op] ? (m_own_ip[op] == ip && m_own_vc[op] == iv)
                                               : head[ip][iv];
            end
    endfunction

    task automatic do_reset(input int cycles);
        @(negedge clk);
        RSTn = 1'b0;
        clear_inputs();
        model_reset();
        repeat (cycles) @(posedge clk);
        #1;
        check("reset_sw_grant", swg, 0);
        check("reset_xbar_valid", xv, 0);
        check("reset_errs", {cerr, terr}, 0);
        @(negedge clk);
        RSTn = 1'b1;
    endtask

    // One clock: check the mask, play allocator, advance model, check registered outputs.
    task automatic step();
        logic [PN-1:0][VN-1:0] g;
        logic [PN-1:0]         used, dec;
        bit                    fire [PN];
        int                    s, ip, vv, op;
        bit                    done, one_per_in;
        #1;
        compute_m_req();
        check("alloc_request", areq, m_req);
        s_areq = areq;
        g = '0; used = '0;
        s = $urandom_range(0, PN - 1);
        for (int k = 0; k < PN; k++) begin
            ip = (s + k) % PN;
            done = 0;
            for (int v = 0; v < VN; v++) begin
                vv = (v + s) % VN;
                op = int'(tgt[ip][vv]);
                if (!done && m_req[ip][vv] && !used[op]) begin
                    g[ip][vv] = 1'b1; used[op] = 1'b1; done = 1;
                end
            end
        end
        agnt = g;
        @(posedge clk);
        dec = '0;
        e_swg = g;
        for (int i = 0; i < PN; i++) fire[i] = 0;
`ifdef SA_LOCK_TIMEOUT_EN
        for (int o = 0; o < PN; o++)
            if (m_lock[o]) begin
                if (!m_req[m_own_ip[o]][m_own_vc[o]]) begin
                    m_idle[o]++;
                    if (m_idle[o] == LT) fire[o] = 1;
                end else m_idle[o] = 0;
            end
`endif
        for (int i = 0; i < PN; i++)
            for (int v = 0; v < VN; v++)
                if (g[i][v]) begin
                    op = int'(tgt[i][v]);
                    dec[op] = 1'b1;
                    e_xs[op] = 3'(i);
                    if (!m_lock[op]) begin
                        if (head[i][v] && !tail[i][v]) begin
                            m_lock[op] = 1; m_own_ip[op] = i; m_own_vc[op] = v; m_idle[op] = 0;
                        end
                    end else if (m_own_ip[op] == i && m_own_vc[op] == v && tail[i][v]) begin
                        m_lock[op] = 0;
                    end
                end
        for (int o = 0; o < PN; o++) begin
            if (fire[o]) begin m_lock[o] = 0; m_idle[o] = 0; m_terr = 1; end
            if (cin[o] && m_cred[o] == BD) m_cerr = 1;
            if (dec[o] && !cin[o]) m_cred[o]--;
            else if (cin[o] && !dec[o] && m_cred[o] < BD) m_cred[o]++;
        end
        e_xv = dec;
        #1;
        check("sw_grant", swg, e_swg);
        check("xbar_valid", xv, e_xv);
        check("xbar_sel", xs, e_xs);
        check("credit_err", cerr, m_cerr);
        check("timeout_err", terr, m_terr);
        one_per_in = 1;
        for (int i = 0; i < PN; i++) if ($countones(swg[i]) > 1) one_per_in = 0;
        check("one_grant_per_input", one_per_in, 1);
    endtask

    int cnt;

    initial begin
        RSTn = 1'b0;
        clear_inputs();
        model_reset();
        do_reset(2);

        // Four grants to EAST after reset, from four different inputs
        for (int i = 0; i < 4; i++) begin
            req[i][0] = 1; tgt[i][0] = 3'd3; head[i][0] = 1; tail[i][0] = 1;
        end
        cnt = 0;
        for (int c = 0; c < 4; c++) begin step(); cnt += $countones(swg); end
        check("east_four_grants", cnt, 4);

        // Single-flit packet never locks
        do_reset(1);
        req[2][1] = 1; tgt[2][1] = 3'd3; head[2][1] = 1; tail[2][1] = 1;
        step();
        check("single_sw_grant", swg[2][1], 1);
        check("single_xbar_sel_east", xs[3], 2);
        check("single_xbar_valid_east", xv[3], 1);
        req[2][1] = 0;
        req[0][0] = 1; tgt[0][0] = 3'd3; head[0][0] = 1; tail[0][0] = 1;
        step();
        check("east_not_locked", s_areq[0][0], 1);

        // Packet lock on WEST
        do_reset(1);
        req[0][0] = 1; tgt[0][0] = 3'd4; head[0][0] = 1; tail[0][0] = 0;
        step();
        check("lock_head_grant", swg[0][0], 1);
        head[0][0] = 0;
        req[2][0] = 1; tgt[2][0] = 3'd4; head[2][0] = 1; tail[2][0] = 0;
        step();
        check("lock_mask_body", s_areq[2][0], 0);
        check("lock_body_grant", swg[0][0], 1);
        tail[0][0] = 1;
        step();
        check("lock_mask_tail", s_areq[2][0], 0);
        req[0][0] = 0;
        step();
        check("lock_released_req", s_areq[2][0], 1);
        check("lock_released_grant", swg[2][0], 1);

        // Credit exhaustion on NORTH
        do_reset(1);
        req[1][0] = 1; tgt[1][0] = 3'd1; head[1][0] = 1; tail[1][0] = 1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin step(); cnt += int'(swg[1][0]); end
        check("north_grants", cnt, 4);
        check("north_fifth_masked", s_areq[1][0], 0);
        cin[1] = 1;
        step();
        check("north_credit_same_cycle", s_areq[1][0], 0);
        cin[1] = 0;
        step();
        check("north_after_credit", swg[1][0], 1);

        // Simultaneous grant and credit on SOUTH leaves the count unchanged
        do_reset(1);
        req[3][0] = 1; tgt[3][0] = 3'd2; head[3][0] = 1; tail[3][0] = 1;
        step();
        cin[2] = 1;
        step();
        check("south_grant_with_credit", swg[3][0], 1);
        cin[2] = 0;
        cnt = 0;
        for (int c = 0; c < 4; c++) begin step(); cnt += int'(swg[3][0]); end
        check("south_remaining", cnt, 3);

        // Credit overflow
        do_reset(1);
        cin[2] = 1;
        step();
        check("credit_overflow_err", cerr, 1);
        cin[2] = 0;
        step();
        check("credit_err_sticky", cerr, 1);

`ifdef SA_LOCK_TIMEOUT_EN
        do_reset(1);
        req[0][0] = 1; tgt[0][0] = 3'd0; head[0][0] = 1; tail[0][0] = 0;
        step();
        req[0][0] = 0;
        req[1][0] = 1; tgt[1][0] = 3'd0; head[1][0] = 1; tail[1][0] = 0;
        repeat (7) step();
        check("timeout_not_yet", terr, 0);
        check("timeout_still_masked", s_areq[1][0], 0);
        step();
        check("timeout_fired", terr, 1);
        step();
        check("timeout_unlocked", s_areq[1][0], 1);
`endif

        // Randomized traffic
        do_reset(1);
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < PN; i++)
                for (int v = 0; v < VN; v++) begin
                    req[i][v]  = ($urandom_range(0, 9) < 6);
                    tgt[i][v]  = 3'($urandom_range(0, PN - 1));
                    head[i][v] = $urandom_range(0, 1) == 1;
                    tail[i][v] = $urandom_range(0, 2) == 0;
                end
            for (int o = 0; o < PN; o++)
                cin[o] = (m_cred[o] < BD) && ($urandom_range(0, 3) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
